// File: rtl/stencil_stream_ctrl.sv
// -----------------------------------------------------------------------------
// stencil_stream_ctrl
//
// Sequencer for one 3D stencil core. A start pulse (accepted only while idle)
// latches the weight vector and streams INPUT_NO words from a 1-cycle-latency
// input RAM into the core. An upstream hold pauses the reads. It then collects
// exactly OUTPUT_NO core results, forwards each with its 0-based index, and
// pulses done.
//
// Optional feature: define STENCIL_CTRL_TIMEOUT_EN to enable a drain watchdog.
// The watchdog ends a run (err_timeout + done) after TIMEOUT idle DRAIN cycles.
// Without the macro, DRAIN waits indefinitely and err_timeout is tied to 0.
//
// Ports
//   clock, reset       : rising-edge clock, asynchronous active-low reset
//   start, hold        : run request (idle only) / pause input reads
//   cfg_weight         : weight vector, sampled on an accepted start
//   in_rd_en, in_addr  : input RAM read strobe and address
//   in_rd_data         : RAM data, valid the cycle after in_rd_en
//   core_in_ready/matrix/weight : core io_in_* drive
//   core_out_data/valid         : core io_out_* results
//   res_valid/data/index        : forwarded result stream
//   busy, done         : state != IDLE / one-cycle completion pulse
//   err_extra          : sticky, an unexpected core result arrived
//   err_timeout        : sticky, the drain watchdog fired
// -----------------------------------------------------------------------------
module stencil_stream_ctrl #(
  parameter int BW        = 32,
  parameter int ST        = 1,
  parameter int POINTS    = 7,
  parameter int INPUT_NO  = 113,
  parameter int OUTPUT_NO = 27,
  parameter int TIMEOUT   = 256,
  localparam int AW       = $clog2(INPUT_NO),
  localparam int IW       = $clog2(OUTPUT_NO)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hold,
  input  logic [POINTS*BW-1:0] cfg_weight,
  output logic                 in_rd_en,
  output logic [AW-1:0]        in_addr,
  input  logic [ST*BW-1:0]     in_rd_data,
  output logic                 core_in_ready,
  output logic [ST*BW-1:0]     core_in_matrix,
  output logic [POINTS*BW-1:0] core_in_weight,
  input  logic [ST*BW-1:0]     core_out_data,
  input  logic                 core_out_valid,
  output logic                 res_valid,
  output logic [ST*BW-1:0]     res_data,
  output logic [IW-1:0]        res_index,
  output logic                 busy,
  output logic                 done,
  output logic                 err_extra,
  output logic                 err_timeout
);

  // Counters must be able to hold the terminal counts themselves.
  localparam int CW = $clog2(INPUT_NO + 1);
  localparam int RW = $clog2(OUTPUT_NO + 1);

  localparam logic [CW-1:0] RD_TOTAL  = CW'(INPUT_NO);
  localparam logic [CW-1:0] RD_LAST   = CW'(INPUT_NO - 1);
  localparam logic [RW-1:0] RES_TOTAL = RW'(OUTPUT_NO);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         rd_cnt;
  logic [RW-1:0]         res_cnt;
  logic [POINTS*BW-1:0]  weight_q;
  logic [ST*BW-1:0]      matrix_q;
  logic                  ready_q;

  logic start_acc;
  logic rd_fire;
  logic last_rd;
  logic collecting;
  logic capture;
  logic extra;
  logic timeout_hit;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign start_acc  = (state == S_IDLE) && start;
  assign rd_fire    = (state == S_STREAM) && !hold && (rd_cnt < RD_TOTAL);
  assign last_rd    = rd_fire && (rd_cnt == RD_LAST);
  assign collecting = (state == S_STREAM) || (state == S_DRAIN);
  assign capture    = core_out_valid && collecting && (res_cnt < RES_TOTAL);
  // Anything the core emits that cannot be captured is flagged, never forwarded.
  assign extra      = core_out_valid && !capture;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_acc) state_nxt = S_STREAM;
      // Leave STREAM the cycle the final beat reaches the core.
      S_STREAM: if (last_rd) state_nxt = S_DRAIN;
      S_DRAIN:  if (res_cnt == RES_TOTAL || timeout_hit) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign in_rd_en = rd_fire;
  assign in_addr  = rd_cnt[AW-1:0];

  // ---------------------------------------------------------------------------
  // Input alignment: the RAM answers one cycle after the strobe, so the core
  // sees the word in the same cycle as the delayed strobe; matrix_q keeps the
  // last presented word visible while the stream is paused.
  // ---------------------------------------------------------------------------
  assign core_in_ready  = ready_q;
  assign core_in_matrix = ready_q ? in_rd_data : matrix_q;
  assign core_in_weight = weight_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the weight register is reset (not left free) because
      // core_in_weight must read 0 straight out of reset.
      weight_q  <= '0;
      matrix_q  <= '0;
      ready_q   <= 1'b0;
      rd_cnt    <= '0;
      res_cnt   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
      err_extra <= 1'b0;
    end else begin
      ready_q   <= rd_fire;
      res_valid <= capture;
      if (ready_q) matrix_q <= in_rd_data;

      if (start_acc) begin
        weight_q <= cfg_weight;
        rd_cnt   <= '0;
        res_cnt  <= '0;
      end else begin
        if (rd_fire) rd_cnt  <= rd_cnt + CW'(1);
        if (capture) res_cnt <= res_cnt + RW'(1);
      end

      if (capture) begin
        res_data  <= core_out_data;
        res_index <= res_cnt[IW-1:0];
      end

      // Cleared by an accepted start; a new error in the same cycle still wins.
      err_extra <= (err_extra && !start_acc) || extra;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain watchdog
  // ---------------------------------------------------------------------------
`ifdef STENCIL_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wd_cnt;
  logic          err_timeout_q;

  // wd_cnt is 0 on the first DRAIN cycle and in the cycle after each capture;
  // firing at TIMEOUT-1 puts done exactly TIMEOUT cycles after that point.
  assign timeout_hit = (state == S_DRAIN) && !capture &&
                       (res_cnt != RES_TOTAL) && (wd_cnt == WD_LAST);
  assign err_timeout = err_timeout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state != S_DRAIN || capture) wd_cnt <= '0;
      else                             wd_cnt <= wd_cnt + TW'(1);

      if (start_acc)        err_timeout_q <= 1'b0;
      else if (timeout_hit) err_timeout_q <= 1'b1;
    end
  end
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign err_timeout    = 1'b0;
  assign timeout_unused = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_stencil_stream_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for stencil_stream_ctrl. A 1-cycle-latency RAM model
// feeds the DUT; core results are injected from per-cycle plans. A reference
// model derives beat timing, result order and completion time directly from
// the hold/result plans. Build with +define+STENCIL_CTRL_TIMEOUT_EN to cover
// the watchdog variant.
// -----------------------------------------------------------------------------
module tb_stencil_stream_ctrl;

  localparam int BW        = 32;
  localparam int ST        = 1;
  localparam int POINTS    = 7;
  localparam int INPUT_NO  = 113;
  localparam int OUTPUT_NO = 27;
  localparam int TIMEOUT   = 16;
  localparam int AW        = $clog2(INPUT_NO);
  localparam int IW        = $clog2(OUTPUT_NO);
  localparam int MAXC      = 512;

`ifdef STENCIL_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 hold;
  logic [POINTS*BW-1:0] cfg_weight;
  logic                 in_rd_en;
  logic [AW-1:0]        in_addr;
  logic [ST*BW-1:0]     in_rd_data = '0;
  logic                 core_in_ready;
  logic [ST*BW-1:0]     core_in_matrix;
  logic [POINTS*BW-1:0] core_in_weight;
  logic [ST*BW-1:0]     core_out_data;
  logic                 core_out_valid;
  logic                 res_valid;
  logic [ST*BW-1:0]     res_data;
  logic [IW-1:0]        res_index;
  logic                 busy;
  logic                 done;
  logic                 err_extra;
  logic                 err_timeout;

  stencil_stream_ctrl #(
    .BW(BW), .ST(ST), .POINTS(POINTS), .INPUT_NO(INPUT_NO),
    .OUTPUT_NO(OUTPUT_NO), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .hold(hold),
    .cfg_weight(cfg_weight), .in_rd_en(in_rd_en), .in_addr(in_addr),
    .in_rd_data(in_rd_data), .core_in_ready(core_in_ready),
    .core_in_matrix(core_in_matrix), .core_in_weight(core_in_weight),
    .core_out_data(core_out_data), .core_out_valid(core_out_valid),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .busy(busy), .done(done), .err_extra(err_extra), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  // Input RAM model: data appears the cycle after the read strobe.
  logic [ST*BW-1:0] mem [INPUT_NO];
  always @(posedge clock) if (in_rd_en) in_rd_data <= mem[in_addr];

  int n_cmp = 0;
  int n_bad = 0;

  bit                   hold_plan [MAXC];
  bit                   ov_plan   [MAXC];
  logic [ST*BW-1:0]     ov_data   [MAXC];
  logic [POINTS*BW-1:0] cur_w;

  typedef struct {
    int hold_at;
    int hold_len;
    int extra_at;
    int exp_last_beat;
    int exp_done;
    bit exp_err_extra;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":ctl"}, {in_rd_en, in_addr, core_in_ready, res_valid, res_index,
                          busy, done, err_extra, err_timeout}, '0);
    check({tag, ":matrix"}, core_in_matrix, '0);
    check({tag, ":res_data"}, res_data, '0);
    check({tag, ":weight"}, {63'd0, |core_in_weight}, '0);
  endtask

  task automatic clear_plans();
    for (int i = 0; i < MAXC; i++) begin
      hold_plan[i] = 1'b0;
      ov_plan[i]   = 1'b0;
      ov_data[i]   = $urandom;
    end
    for (int i = 0; i < POINTS; i++) cur_w[i*BW +: BW] = $urandom;
  endtask

  task automatic nominal_results();
    for (int k = 0; k < OUTPUT_NO; k++) ov_plan[20 + 4*k] = 1'b1;
  endtask

  task automatic drive_idle();
    start = 1'b0; hold = 1'b0; core_out_valid = 1'b0; core_out_data = '0;
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One run: model the expected behaviour from the plans, drive, observe, compare.
  task automatic do_run(input string tag, input int busy_at,
                        output int last_beat, output int done_cyc, output bit ee);
    int exp_rdy[$];
    int exp_rcyc[$];
    logic [ST*BW-1:0] exp_rdat[$];
    int obs_rd[$];
    int obs_rdy[$];
    logic [ST*BW-1:0] obs_beat[$];
    int obs_rcyc[$];
    int obs_ridx[$];
    logic [ST*BW-1:0] obs_rdat[$];
    int obs_done[$];
    int reads, drain, n, last_cap, last_ov, exp_done, ncyc, t;
    int first_busy, last_busy, wbad, mism;
    bit exp_ee;

    // Reference model: a read happens in every un-held cycle until INPUT_NO
    // reads are issued; its beat reaches the core one cycle later.
    reads = 0;
    for (int c = 1; c < MAXC - 1; c++)
      if (!hold_plan[c] && reads < INPUT_NO) begin
        exp_rdy.push_back(c + 1);
        reads++;
      end
    drain = exp_rdy[$];
    n = 0; last_cap = 0; last_ov = 0; exp_ee = 1'b0;
    for (int c = 1; c < MAXC; c++)
      if (ov_plan[c]) begin
        last_ov = c;
        if (n < OUTPUT_NO) begin
          exp_rcyc.push_back(c + 1);
          exp_rdat.push_back(ov_data[c]);
          n++;
          last_cap = c;
        end else begin
          exp_ee = 1'b1;
        end
      end
    t = last_cap + 1;
    if (drain > t) t = drain;
    if (n == OUTPUT_NO) exp_done = t + 1;
    else if (TO_EN)     exp_done = t + TIMEOUT;
    else                exp_done = -1;
    ncyc = (exp_done > 0) ? exp_done + 4 : drain + 3*TIMEOUT + 20;
    if (last_ov + 2 > ncyc) ncyc = last_ov + 2;
    if (ncyc > MAXC - 1) ncyc = MAXC - 1;

    // Stimulus and observation.
    first_busy = -1; last_busy = -1; wbad = 0;
    @(posedge clock); #1;
    drive_idle();
    start = 1'b1;
    cfg_weight = cur_w;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clock); #1;
      start = (c == busy_at);
      if (c == busy_at) cfg_weight = ~cur_w;
      hold = hold_plan[c];
      core_out_valid = ov_plan[c];
      core_out_data = ov_data[c];
      @(negedge clock);
      if (in_rd_en) obs_rd.push_back(int'(in_addr));
      if (core_in_ready) begin
        obs_rdy.push_back(c);
        obs_beat.push_back(core_in_matrix);
      end
      if (res_valid) begin
        obs_rcyc.push_back(c);
        obs_ridx.push_back(int'(res_index));
        obs_rdat.push_back(res_data);
      end
      if (done) obs_done.push_back(c);
      if (busy) begin
        if (first_busy < 0) first_busy = c;
        last_busy = c;
      end
      if (core_in_weight !== cur_w) wbad++;
    end
    @(posedge clock); #1;
    drive_idle();

    check({tag, ":rd_count"}, obs_rd.size(), INPUT_NO);
    mism = 0;
    foreach (obs_rd[i]) if (obs_rd[i] != i) mism++;
    check({tag, ":rd_addr_seq_errs"}, mism, 0);
    check({tag, ":beat_count"}, obs_rdy.size(), exp_rdy.size());
    mism = 0;
    foreach (obs_rdy[i]) if (i >= exp_rdy.size() || obs_rdy[i] != exp_rdy[i]) mism++;
    check({tag, ":beat_timing_errs"}, mism, 0);
    mism = 0;
    foreach (obs_beat[i]) if (i >= INPUT_NO || obs_beat[i] !== mem[i]) mism++;
    check({tag, ":beat_data_errs"}, mism, 0);
    check({tag, ":res_count"}, obs_rcyc.size(), exp_rcyc.size());
    mism = 0;
    foreach (obs_rcyc[i])
      if (i >= exp_rcyc.size() || obs_rcyc[i] != exp_rcyc[i] ||
          obs_ridx[i] != i || obs_rdat[i] !== exp_rdat[i]) mism++;
    check({tag, ":res_order_errs"}, mism, 0);
    check({tag, ":done_pulses"}, obs_done.size(), (exp_done > 0) ? 1 : 0);
    done_cyc = (obs_done.size() > 0) ? obs_done[0] : -1;
    check({tag, ":done_cycle"}, done_cyc, exp_done);
    check({tag, ":busy_first"}, first_busy, 1);
    check({tag, ":busy_last"}, last_busy, (exp_done > 0) ? exp_done : ncyc);
    check({tag, ":weight_bad_cycles"}, wbad, 0);
    check({tag, ":err_extra"}, err_extra, exp_ee);
    check({tag, ":err_timeout"}, err_timeout, TO_EN && (n < OUTPUT_NO));
    last_beat = (obs_rdy.size() > 0) ? obs_rdy[$] : -1;
    ee = err_extra;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int lb, dc, c0;
    bit ee;

    vecs[0] = '{hold_at: 0,   hold_len: 0, extra_at: 0,   exp_last_beat: 114, exp_done: 126, exp_err_extra: 1'b0};
    vecs[1] = '{hold_at: 10,  hold_len: 3, extra_at: 0,   exp_last_beat: 117, exp_done: 126, exp_err_extra: 1'b0};
    vecs[2] = '{hold_at: 1,   hold_len: 5, extra_at: 0,   exp_last_beat: 119, exp_done: 126, exp_err_extra: 1'b0};
    vecs[3] = '{hold_at: 113, hold_len: 2, extra_at: 0,   exp_last_beat: 116, exp_done: 126, exp_err_extra: 1'b0};
    vecs[4] = '{hold_at: 60,  hold_len: 1, extra_at: 125, exp_last_beat: 115, exp_done: 126, exp_err_extra: 1'b1};
    vecs[5] = '{hold_at: 0,   hold_len: 0, extra_at: 129, exp_last_beat: 114, exp_done: 126, exp_err_extra: 1'b1};

    for (int i = 0; i < INPUT_NO; i++) mem[i] = $urandom;
    reset = 1'b0;
    cfg_weight = '0;
    drive_idle();

    // Reset state, during and just after reset.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("post_release");

    // Table-driven runs.
    for (int v = 0; v < 6; v++) begin
      clear_plans();
      for (int j = 0; j < vecs[v].hold_len; j++) hold_plan[vecs[v].hold_at + j] = 1'b1;
      nominal_results();
      if (vecs[v].extra_at > 0) ov_plan[vecs[v].extra_at] = 1'b1;
      do_run($sformatf("vec%0d", v), 0, lb, dc, ee);
      check($sformatf("vec%0d:last_beat", v), lb, vecs[v].exp_last_beat);
      check($sformatf("vec%0d:done_at", v), dc, vecs[v].exp_done);
      check($sformatf("vec%0d:err_extra_tbl", v), ee, vecs[v].exp_err_extra);
    end

    // Result while idle: flagged, not forwarded.
    @(posedge clock); #1;
    core_out_valid = 1'b1;
    core_out_data = 32'hdead_beef;
    @(posedge clock); #1;
    core_out_valid = 1'b0;
    @(negedge clock);
    check("idle_extra:err_extra", err_extra, 1'b1);
    check("idle_extra:res_valid", res_valid, 1'b0);
    check("idle_extra:busy", busy, 1'b0);

    // Start while busy is ignored; this run also shows err_extra is cleared.
    clear_plans();
    nominal_results();
    do_run("busy_start", 50, lb, dc, ee);
    check("busy_start:last_beat", lb, 114);
    check("busy_start:done_at", dc, 126);

    // Only 26 results: watchdog fires, or DRAIN waits forever without it.
    clear_plans();
    nominal_results();
    ov_plan[20 + 4*26] = 1'b0;
    do_run("short", 0, lb, dc, ee);
    check("short:done_at", dc, TO_EN ? 137 : -1);
    apply_reset();

    // Asynchronous reset in the middle of STREAM.
    clear_plans();
    ov_plan[20] = 1'b1;
    ov_plan[22] = 1'b1;
    @(posedge clock); #1;
    start = 1'b1;
    cfg_weight = cur_w;
    for (int c = 1; c < 40; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
      core_out_valid = ov_plan[c];
      core_out_data = ov_data[c] | 32'd1;
    end
    @(posedge clock); #1;
    core_out_valid = 1'b0;
    check("rst_mid:pre", {busy, core_in_ready, |res_data}, 3'b111);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_mid");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_plans();
    nominal_results();
    do_run("post_reset", 0, lb, dc, ee);
    check("post_reset:done_at", dc, 126);

    // Randomized hold patterns and result spacing against the reference model.
    for (int r = 0; r < 6; r++) begin
      clear_plans();
      for (int c = 1; c < 200; c++) hold_plan[c] = ($urandom_range(0, 3) == 0);
      c0 = $urandom_range(5, 100);
      for (int k = 0; k < OUTPUT_NO; k++) begin
        ov_plan[c0] = 1'b1;
        c0 += $urandom_range(1, 8);
      end
      do_run($sformatf("rand%0d", r), 0, lb, dc, ee);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
